// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge channel between the IF stage and imem.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit.sv
// IF-stage PC sequencer: issues imem fetches, parks words across ID stalls and
// applies branch/jump redirects after the one-instruction delay slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_id,
    input  logic         redir_valid,
    input  logic [31:0]  redir_target,
    fetch_unit_if.master imem,
    output logic         id_valid,
    output logic [31:0]  id_instr,
    output logic [31:0]  id_pc,
    output logic [31:0]  id_pc8,
    output logic         misalign_err
);

    typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_word;
    logic        buf_valid;
    logic        pend_valid;
    logic [31:0] pend_target;

    logic        word_avail;
    logic [31:0] word;
    logic        xfer;
    logic        park;
    logic        redir_now;
    logic [31:0] eff_target;
    logic [31:0] next_pc;

    // pc always names the in-flight or parked fetch, so it doubles as the request address.
    assign imem.addr = pc;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        word_avail = 1'b0;
        word       = imem.rdata;
        next_pc    = pc + 32'd4;

        if (state == REQ && imem.ack) begin
            word_avail = 1'b1;
        end else if (state == HOLD && buf_valid) begin
            word_avail = 1'b1;
            word       = buf_word;
        end

        redir_now  = id_valid && !stall_id && redir_valid;
        eff_target = {redir_target[31:2], 2'b00};
        xfer       = word_avail && (!id_valid || !stall_id);
        park       = (state == REQ) && imem.ack && id_valid && stall_id;

        // A redirect seen this cycle bypasses any older pending one (last wins).
        if (redir_now) begin
            next_pc = eff_target;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            imem.req     <= 1'b0;
            id_valid     <= 1'b0;
            id_instr     <= 32'h0;
            id_pc        <= 32'h0;
            id_pc8       <= 32'h0;
            buf_valid    <= 1'b0;
            pend_valid   <= 1'b0;
            pend_target  <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (redir_now && redir_target[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end

            case (state)
                BOOT: begin
                    state    <= REQ;
                    imem.req <= 1'b1;
                end
                default: begin
                    if (xfer) begin
                        id_instr   <= word;
                        id_pc      <= pc;
                        id_pc8     <= pc + 32'd8;
                        id_valid   <= 1'b1;
                        pc         <= next_pc;
                        state      <= REQ;
                        imem.req   <= 1'b1;
                        buf_valid  <= 1'b0;
                        pend_valid <= 1'b0;
                    end else if (park) begin
                        state     <= HOLD;
                        imem.req  <= 1'b0;
                        buf_valid <= 1'b1;
                    end else if (redir_now) begin
                        // Delay slot still in flight: remember where to go after it.
                        pend_valid  <= 1'b1;
                        pend_target <= eff_target;
                    end

                    if (!word_avail && !stall_id) begin
                        id_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // NOTE: the parked word is only consumed while buf_valid is set, so its data flops need no reset.
    always_ff @(posedge clk) begin
        if (park) begin
            buf_word <= imem.rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: program-order stream model plus per-cycle
// handshake/IF-ID checks, and literal expectations for each scenario.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          NS       = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_id = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = 32'h0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        misalign_err;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_id     (stall_id),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .imem         (imem),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_pc8       (id_pc8),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scenario controls
    int          lat = 0;
    logic        br_en = 1'b0;
    logic [31:0] br_pc = 32'h0;
    logic [31:0] br_tgt = 32'h0;
    logic        force_ack = 1'b0;
    int          stall_left = 0;
    int          wait_cnt = 0;

    // Expected program-order fetch stream and observation logs
    logic [31:0] s [NS];
    logic [31:0] req_log [$];
    int          req_cyc [$];
    logic [31:0] deliv_log [$];
    logic [31:0] deliv_pc8 [$];
    int          cyc = 0;
    int          req_low_cnt = 0;
    int          watch_cnt = 0;
    logic [31:0] watch_addr = 32'hFFFF_FFFF;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0] ^ 16'h5A5A};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instruction stream: sequential, except the slot after a taken branch's delay slot.
    task automatic build_stream();
        s[0] = RESET_PC;
        s[1] = RESET_PC + 32'd4;
        for (int i = 2; i < NS; i++) begin
            if (br_en && s[i-2] == br_pc) s[i] = {br_tgt[31:2], 2'b00};
            else                          s[i] = s[i-1] + 32'd4;
        end
    endtask

    // Memory responder latency counter
    always @(posedge clk or negedge reset) begin
        if (!reset)                          wait_cnt <= 0;
        else if (imem.req && imem.ack)       wait_cnt <= 0;
        else if (imem.req)                   wait_cnt <= wait_cnt + 1;
    end

    task automatic drive();
        stall_id = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        redir_valid  = br_en && id_valid && (id_pc == br_pc);
        redir_target = br_tgt;
        imem.ack     = force_ack || (imem.req && wait_cnt >= lat);
        imem.rdata   = force_ack ? 32'hDEAD_BEEF : instr_of(imem.addr);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        drive();
    endtask

    task automatic clear_logs();
        req_log.delete();
        req_cyc.delete();
        deliv_log.delete();
        deliv_pc8.delete();
        req_low_cnt = 0;
        watch_cnt   = 0;
    endtask

    task automatic start_test(input int l, input logic be, input logic [31:0] bp,
                              input logic [31:0] bt, input logic [31:0] wa);
        @(negedge clk);
        #1;
        reset      = 1'b0;
        lat        = l;
        br_en      = be;
        br_pc      = bp;
        br_tgt     = bt;
        watch_addr = wa;
        stall_left = 0;
        force_ack  = 1'b0;
        build_stream();
        clear_logs();
        drive();
        tick();
        @(negedge clk);
        #1;
        reset = 1'b1;
        drive();
    endtask

    // Compare process: every cycle, judge outputs against the stream model.
    logic        have_prev = 1'b0;
    logic        p_idv, p_stall, p_req, p_ack, p_redir;
    logic [31:0] p_addr, p_idpc, p_instr, p_tgt;
    int          held = 0;
    int          k = 0;
    int          j = 0;
    logic        mis_exp = 1'b0;

    always @(negedge clk) begin
        logic avail;
        logic hold;
        #2;
        if (!reset) begin
            check("rst_req", imem.req, 1'b0);
            check("rst_addr", imem.addr, RESET_PC);
            check("rst_id_valid", id_valid, 1'b0);
            check("rst_id_instr", id_instr, 32'h0);
            check("rst_id_pc", id_pc, 32'h0);
            check("rst_id_pc8", id_pc8, 32'h0);
            check("rst_misalign", misalign_err, 1'b0);
            have_prev = 1'b0;
            held      = 0;
            k         = 0;
            j         = 0;
            mis_exp   = 1'b0;
        end else begin
            cyc++;
            if (!have_prev) begin
                check("boot_req", imem.req, 1'b0);
            end else begin
                avail = (p_req && p_ack) || (held > 0);
                hold  = p_idv && p_stall;
                if (hold) begin
                    check("hold_valid", id_valid, 1'b1);
                    check("hold_pc", id_pc, p_idpc);
                    check("hold_instr", id_instr, p_instr);
                end else begin
                    check("id_valid", id_valid, avail);
                end
                if (avail && !hold) begin
                    check("deliv_pc", id_pc, (k < NS) ? s[k] : 32'hFFFF_FFFF);
                    k++;
                    deliv_log.push_back(id_pc);
                    deliv_pc8.push_back(id_pc8);
                end
                if (id_valid) begin
                    check("id_instr", id_instr, instr_of(id_pc));
                    check("id_pc8", id_pc8, id_pc + 32'd8);
                end
                if (p_req && p_ack) begin
                    check("req_addr", p_addr, (j < NS) ? s[j] : 32'hFFFF_FFFF);
                    j++;
                    req_log.push_back(p_addr);
                    req_cyc.push_back(cyc);
                end
                held = held + ((p_req && p_ack) ? 1 : 0) - ((avail && !hold) ? 1 : 0);
                if (p_req && !p_ack) begin
                    check("req_stable", imem.req, 1'b1);
                    check("addr_stable", imem.addr, p_addr);
                end
                check("req_level", imem.req, held == 0);
                if (!imem.req) req_low_cnt++;
                if (imem.req && imem.addr == watch_addr) watch_cnt++;
                if (p_idv && !p_stall && p_redir && p_tgt[1:0] != 2'b00) mis_exp = 1'b1;
                check("misalign", misalign_err, mis_exp);
            end
            p_idv     = id_valid;
            p_stall   = stall_id;
            p_req     = imem.req;
            p_ack     = imem.ack;
            p_addr    = imem.addr;
            p_idpc    = id_pc;
            p_instr   = id_instr;
            p_redir   = redir_valid;
            p_tgt     = redir_target;
            have_prev = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        int   n300c;
        imem.ack   = 1'b0;
        imem.rdata = 32'h0;

        // Sequential fetch with immediate ack
        start_test(0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF);
        repeat (8) tick();
        check("t1_req0", req_log[0], 32'h3000);
        check("t1_req1", req_log[1], 32'h3004);
        check("t1_req2", req_log[2], 32'h3008);
        check("t1_back_to_back_a", req_cyc[1] - req_cyc[0], 1);
        check("t1_back_to_back_b", req_cyc[2] - req_cyc[1], 1);
        check("t1_first_id_pc", deliv_log[0], 32'h3000);
        check("t1_first_id_pc8", deliv_pc8[0], 32'h3008);

        // Branch at 0x3004 -> 0x3100, immediate ack
        start_test(0, 1'b1, 32'h3004, 32'h3100, 32'hFFFF_FFFF);
        repeat (10) tick();
        check("t2_req2_slot", req_log[2], 32'h3008);
        check("t2_req3_target", req_log[3], 32'h3100);
        check("t2_deliv2_slot", deliv_log[2], 32'h3008);
        check("t2_deliv3_target", deliv_log[3], 32'h3100);
        n300c = 0;
        foreach (req_log[i]) if (req_log[i] == 32'h300C) n300c++;
        check("t2_no_300c", n300c, 0);

        // Latency 3, redirect to 0x3200 while the delay slot is in flight
        start_test(3, 1'b1, 32'h3004, 32'h3200, 32'h3008);
        repeat (24) tick();
        check("t3_req2_slot", req_log[2], 32'h3008);
        check("t3_req3_target", req_log[3], 32'h3200);
        check("t3_slot_req_cycles", watch_cnt, 4);
        check("t3_deliv3_target", deliv_log[3], 32'h3200);

        // ID stall for 4 cycles while an ack arrives
        start_test(0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (id_valid && id_pc == 32'h3008) begin
                stall_left = 4;
                found      = 1'b1;
            end
            drive();
        end
        check("t4_reached_3008", found, 1'b1);
        repeat (8) tick();
        check("t4_hold_cycles", req_low_cnt, 4);
        check("t4_deliv_after_stall", deliv_log[3], 32'h300C);
        check("t4_req_parked", req_log[3], 32'h300C);
        check("t4_req_resume", req_log[4], 32'h3010);

        // Misaligned redirect target
        start_test(0, 1'b1, 32'h3004, 32'h3102, 32'hFFFF_FFFF);
        repeat (12) tick();
        check("t5_req3_aligned", req_log[3], 32'h3100);
        check("t5_deliv3_aligned", deliv_log[3], 32'h3100);
        check("t5_misalign_sticky", misalign_err, 1'b1);

        // Reset mid-request (latency 2), stray ack after release
        start_test(2, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF);
        repeat (2) tick();
        check("t6_req_in_flight", imem.req, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        drive();
        tick();
        @(negedge clk);
        #1;
        reset     = 1'b1;
        force_ack = 1'b1;
        clear_logs();
        drive();
        @(negedge clk);
        #1;
        force_ack = 1'b0;
        drive();
        repeat (12) tick();
        check("t6_first_req", req_log[0], 32'h3000);
        check("t6_first_deliv", deliv_log[0], 32'h3000);
        check("t6_second_deliv", deliv_log[1], 32'h3004);

        @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF-stage PC sequencer for the pipelined MIPS core. It consumes the branch/jump target that ID computes, issues instruction-memory reads over a req/ack handshake, and loads the IF/ID pipeline register.
- It honours the one-instruction delay slot, ID stalls, and a variable-latency instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, address of the first fetch after reset.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- stall_id  input  1  hazard unit: ID must hold its instruction this cycle.
- redir_valid  input  1  the branch/jump in ID is taken; meaningful only when id_valid && !stall_id.
- redir_target  input  32  taken branch/jump/jr target from ID.
- imem_req  output  1  fetch request.
- imem_addr  output  32  word address of the request.
- imem_ack  input  1  read data valid; completes the request.
- imem_rdata  input  32  instruction word.
- id_valid  output  1  IF/ID holds a real instruction.
- id_instr  output  32  IF/ID instruction.
- id_pc  output  32  address of id_instr.
- id_pc8  output  32  id_pc+8, the link address.
- misalign_err  output  1  sticky; set when a redirect target has [1:0]!=0.

Behaviour:
- Reset values (async, while reset=0):
  - pc=RESET_PC; state=BOOT.
  - imem_req=0; imem_addr=RESET_PC.
  - id_valid=0; id_instr=0; id_pc=0; id_pc8=0.
  - buf_valid=0; misalign_err=0.
- Reset mid-request: the outstanding request is abandoned. Any imem_ack arriving afterwards in BOOT is ignored.
- States:
  - BOOT: one cycle after reset release, then go to REQ.
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: a fetched word is parked in buffer buf; imem_req=0.
- Handshake:
  - Once imem_req=1, imem_req and imem_addr stay stable until imem_ack.
  - imem_ack while imem_req=0 is ignored.
  - Minimum memory latency is 0 cycles: ack may arrive in the same cycle as the request.
- Transfer: occurs in any cycle where a word is available and (!id_valid || !stall_id). A word is available when state==REQ && imem_ack, or when state==HOLD. On transfer:
  - id_instr <= word; id_pc <= pc; id_pc8 <= pc+8; id_valid <= 1.
  - pc <= next_pc.
  - State goes to REQ, so back-to-back fetches run at 1 instruction per cycle when ack is immediate.
- Ack but no transfer (id_valid && stall_id): buf <= imem_rdata; state goes to HOLD. pc is unchanged.
- No word available and !stall_id: id_valid <= 0 (bubble). When stall_id=1, all IF/ID fields hold.
- pc invariant: pc always equals the address of the in-flight or parked fetch. pc advances only on transfer.
- Delay slot and redirect:
  - A redirect sampled when id_valid && !stall_id && redir_valid targets the instruction after the delay slot.
  - At that moment pc==id_pc+4, which is the delay slot.
  - If a transfer happens in the same cycle, next_pc = redir_target (bypass).
  - Otherwise the redirect is saved in pend_valid/pend_target. The next transfer uses next_pc = pend_target, then clears pend.
  - With no redirect active, next_pc = pc+4. All addition is 32-bit wrapping: 32'hFFFF_FFFC+4 = 0.
  - A second redirect while pend_valid=1 replaces pend_target (last wins).
- Alignment: the effective target is {redir_target[31:2],2'b00}. If redir_target[1:0]!=0, misalign_err <= 1 and stays set until reset.
- Simultaneous events:
  - Redirect plus ack plus transfer in one cycle: the delay slot is delivered to ID and pc=target in the same edge.
  - stall_id during HOLD: the word stays parked. Redirects are not sampled while stall_id=1.

Test Plan:
- Reset release, memory acks immediately -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles. id_pc follows one cycle later; id_pc8 = 0x3008 for id_pc 0x3000.
- Branch at 0x3004 in ID with redir_valid=1 and target 0x3100, immediate ack -> ID receives 0x3008 (delay slot) then 0x3100. 0x300C is never requested.
- Memory ack latency 3 cycles, redirect to 0x3200 while the fetch of the delay slot is in flight -> imem_addr stays at the slot address until ack. The next request is 0x3200. id_valid=0 during the wait cycles.
- stall_id=1 for 4 cycles while ack arrives -> the word is parked in HOLD and imem_req=0. IF/ID is unchanged. On release the parked word enters ID and the fetch resumes at pc+4 with no duplicate or lost instruction.
- Redirect target 0x0000_3102 -> fetch proceeds at 0x3100 and misalign_err=1 until reset.
- Assert reset low mid-request with 2-cycle latency, ack arriving after release -> the stray ack is ignored and the first accepted fetch is 0x3000.
